// File: rtl/capture_pkg.sv
// capture_pkg: shared defaults and state encoding for the capture write path.
//   CAP_DATA_W    - default sample width
//   CAP_ADDR_W    - default capture RAM address width (depth 2^CAP_ADDR_W)
//   CAP_PAGE_LOG2 - default log2 of samples per page
//   cap_state_e   - write controller state encoding
package capture_pkg;

   localparam int unsigned CAP_DATA_W    = 16;
   localparam int unsigned CAP_ADDR_W    = 10;
   localparam int unsigned CAP_PAGE_LOG2 = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PRE  = 2'b01,
      ST_POST = 2'b10,
      ST_DONE = 2'b11
   } cap_state_e;

endpackage

// File: rtl/capture_addr_counter.sv
// capture_addr_counter: circular RAM address counter with page and wrap flags.
// Shared by the capture write path and the readout address generator.
//   clk           - system clock
//   reset         - asynchronous active-high reset
//   inc           - advance the pointer by one (mod 2^ADDR_W)
//   clr           - synchronous clear to 0, wins over inc
//   wr_ptr        - current pointer
//   wrap          - pulses in the cycle an increment rolls the pointer over to 0
//   page_boundary - low PAGE_LOG2 bits of the pointer are all zero
module capture_addr_counter
   import capture_pkg::*;
#(
   parameter int unsigned ADDR_W    = CAP_ADDR_W,
   parameter int unsigned PAGE_LOG2 = CAP_PAGE_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              wrap,
   output logic              page_boundary
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
      end else if (inc) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   assign wrap          = inc && !clr && (&wr_ptr);
   assign page_boundary = (wr_ptr[PAGE_LOG2-1:0] == '0);

endmodule

// File: rtl/capture_write_ctrl.sv
// capture_write_ctrl: writes qualified samples into the circular capture RAM
// while the analyzer FSM is sampling, and reports page/completion status back.
//   clk, reset     - system clock, asynchronous active-high reset
//   idle           - FSM idle (also aborts a capture from any state)
//   pre_trigger    - FSM sampling before the trigger
//   post_trigger   - FSM sampling after the trigger
//   sample_valid   - one-cycle sample strobe
//   sample_data    - sample value
//   post_count     - post-trigger samples to store, taken on first post_trigger cycle
//   mem_we/addr/wdata - registered capture RAM write port
//   pageFull       - write pointer sits on a page boundary
//   complete       - one-cycle pulse once the post-trigger quota is stored
//   trigger_addr   - RAM address of the first post-trigger sample
//   wrapped        - the write pointer has rolled over since the last idle
module capture_write_ctrl
   import capture_pkg::*;
#(
   parameter int unsigned DATA_W    = CAP_DATA_W,
   parameter int unsigned ADDR_W    = CAP_ADDR_W,
   parameter int unsigned PAGE_LOG2 = CAP_PAGE_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              idle,
   input  logic              pre_trigger,
   input  logic              post_trigger,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic [ADDR_W-1:0] post_count,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              pageFull,
   output logic              complete,
   output logic [ADDR_W-1:0] trigger_addr,
   output logic              wrapped
);

   cap_state_e        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wrap;
   logic              page_boundary;
   logic [ADDR_W-1:0] post_cnt;
   logic [ADDR_W-1:0] post_quota;

   logic              sampling_state;
   logic              first_post;
   logic              pre_active;
   logic              post_active;
   logic [ADDR_W-1:0] quota;
   logic [ADDR_W-1:0] post_cnt_base;
   logic [ADDR_W-1:0] post_cnt_next;
   logic              quota_met;
   logic              post_write;
   logic              wr_en;
   logic              finish;

   capture_addr_counter #(
      .ADDR_W    (ADDR_W),
      .PAGE_LOG2 (PAGE_LOG2)
   ) u_addr_counter (
      .clk           (clk),
      .reset         (reset),
      .inc           (wr_en),
      .clr           (idle),
      .wr_ptr        (wr_ptr),
      .wrap          (wrap),
      .page_boundary (page_boundary)
   );

   assign pageFull = page_boundary;

   // The FSM outputs are acted on in the cycle they appear, so the first
   // post_trigger cycle is handled while the state register still says IDLE/PRE.
   always_comb begin
      sampling_state = (state == ST_IDLE) || (state == ST_PRE);
      first_post     = !idle && post_trigger && sampling_state;
      pre_active     = !idle && pre_trigger && !post_trigger && sampling_state;
      post_active    = !idle && (first_post || (state == ST_POST));
      quota          = first_post ? post_count : post_quota;
      post_cnt_base  = first_post ? '0 : post_cnt;
      post_cnt_next  = post_cnt_base + 1'b1;
      // Only true on entry with a zero quota; otherwise the state leaves POST first.
      quota_met      = (post_cnt_base == quota);
      post_write     = post_active && sample_valid && !quota_met;
      wr_en          = (pre_active && sample_valid) || post_write;
      finish         = post_active && (post_write ? (post_cnt_next == quota) : quota_met);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         post_cnt     <= '0;
         post_quota   <= '0;
         trigger_addr <= '0;
         wrapped      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         complete     <= 1'b0;
      end else begin
         // A write decided this cycle lands even if idle aborts the capture.
         mem_we   <= wr_en;
         complete <= finish;
         if (wr_en) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= sample_data;
         end

         if (idle) begin
            state    <= ST_IDLE;
            post_cnt <= '0;
            wrapped  <= 1'b0;
         end else begin
            if (wrap) begin
               wrapped <= 1'b1;
            end
            if (first_post) begin
               trigger_addr <= wr_ptr;
               post_quota   <= post_count;
            end
            if (post_active) begin
               post_cnt <= post_write ? post_cnt_next : post_cnt_base;
            end

            case (state)
               ST_IDLE, ST_PRE: begin
                  if (finish) begin
                     state <= ST_DONE;
                  end else if (first_post) begin
                     state <= ST_POST;
                  end else if (pre_trigger) begin
                     state <= ST_PRE;
                  end
               end
               ST_POST: begin
                  if (finish) begin
                     state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  state <= ST_DONE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_write_ctrl.sv
// tb_capture_write_ctrl: randomized self-checking bench for capture_write_ctrl.
// The reference model tracks the stored sample sequence as a list of expected
// (cycle, address, data) writes plus the expected completion cycle.
module tb_capture_write_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   typedef struct packed {
      logic [31:0]   c;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          idle;
   logic          pre_trigger;
   logic          post_trigger;
   logic          sample_valid;
   logic [DW-1:0] sample_data;
   logic [AW-1:0] post_count;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          pageFull;
   logic          complete;
   logic [AW-1:0] trigger_addr;
   logic          wrapped;

   always #5 clk = ~clk;

   capture_write_ctrl #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .PAGE_LOG2 (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .idle         (idle),
      .pre_trigger  (pre_trigger),
      .post_trigger (post_trigger),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .post_count   (post_count),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .pageFull     (pageFull),
      .complete     (complete),
      .trigger_addr (trigger_addr),
      .wrapped      (wrapped)
   );

   int  n_checks    = 0;
   int  n_fail      = 0;
   int  cyc         = 0;
   int  model_ptr   = 0;
   int  model_writes = 0;
   int  last_trig   = 0;
   wr_t mon_w;
   wr_t got_w[$];
   wr_t exp_w[$];
   int  got_c[$];
   int  exp_c[$];

   // Monitor: log every RAM write and completion pulse with its edge number.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (!reset && mem_we) begin
            mon_w.c = cyc;
            mon_w.a = mem_addr;
            mon_w.d = mem_wdata;
            got_w.push_back(mon_w);
         end
         if (!reset && complete) got_c.push_back(cyc);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Apply one cycle of inputs; c is the edge number that samples them.
   task automatic drive(input logic i, input logic p, input logic q, input logic v,
                        input logic [DW-1:0] d, input logic [AW-1:0] pc, output int c);
      @(negedge clk);
      idle         = i;
      pre_trigger  = p;
      post_trigger = q;
      sample_valid = v;
      sample_data  = d;
      post_count   = pc;
      c            = cyc + 1;
   endtask

   task automatic put_sample(input logic [DW-1:0] d, input int c);
      wr_t w;
      w.c = c;
      w.a = model_ptr[AW-1:0];
      w.d = d;
      exp_w.push_back(w);
      model_ptr    = (model_ptr + 1) % DEPTH;
      model_writes = model_writes + 1;
   endtask

   task automatic go_idle;
      int c;
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      got_w.delete();
      got_c.delete();
      exp_w.delete();
      exp_c.delete();
      model_ptr    = 0;
      model_writes = 0;
   endtask

   task automatic pre_burst(input int n, input bit gaps);
      int            c;
      int            done;
      logic          v;
      logic [DW-1:0] d;
      done = 0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      while (done < n) begin
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         d = DW'($urandom);
         drive(1'b0, 1'b1, 1'b0, v, d, '0, c);
         if (v) begin
            put_sample(d, c);
            done++;
         end
      end
   endtask

   task automatic test_reset;
      int            c;
      logic [DW-1:0] d;
      reset = 1'b1;
      #12;
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_mem: got we %b addr %0d data %h, want 0 0 0", mem_we, mem_addr,
                  mem_wdata);
      end
      n_checks++;
      if (pageFull !== 1'b1 || complete !== 1'b0 || wrapped !== 1'b0 || trigger_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_status: got pf %b cmp %b wr %b trig %0d, want 1 0 0 0", pageFull,
                  complete, wrapped, trigger_addr);
      end
      @(negedge clk);
      reset = 1'b0;
      go_idle();
      pre_burst(30, 1'b1);
      for (int k = 0; k < 7; k++) begin
         d = DW'($urandom);
         drive(1'b0, 1'b0, 1'b1, 1'b1, d, AW'(20), c);
      end
      @(posedge clk);
      #2;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(36) || pageFull !== 1'b0 || trigger_addr !== AW'(30))
      begin
         n_fail++;
         $display("FAIL midcap_state: got we %b addr %0d pf %b trig %0d, want 1 36 0 30", mem_we,
                  mem_addr, pageFull, trigger_addr);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || pageFull !== 1'b1 || complete !== 1'b0 || wrapped !== 1'b0 ||
          trigger_addr !== '0) begin
         n_fail++;
         $display("FAIL midcap_reset: got we %b pf %b cmp %b wr %b trig %0d, want 0 1 0 0 0",
                  mem_we, pageFull, complete, wrapped, trigger_addr);
      end
      @(negedge clk);
      reset = 1'b0;
      last_trig = 0;
      go_idle();
   endtask

   task automatic test_pre_fill;
      int c;
      go_idle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, DW'(i), '0, c);
         n_checks++;
         if (pageFull !== ((i % 16) == 0)) begin
            n_fail++;
            $display("FAIL pre_pagefull ptr %0d: got %b want %b", i, pageFull, (i % 16) == 0);
         end
         put_sample(DW'(i), c);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      n_checks++;
      if (pageFull !== ((model_ptr % 16) == 0)) begin
         n_fail++;
         $display("FAIL pre_pagefull ptr %0d: got %b want %b", model_ptr, pageFull,
                  (model_ptr % 16) == 0);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      n_checks++;
      if (got_w.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL pre_nwrites: got %0d want %0d", got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
         n_checks++;
         if (got_w[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL pre_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", i, got_w[i].c,
                     got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_trigger;
      int            c;
      int            trig;
      logic [DW-1:0] d;
      go_idle();
      pre_burst(5, 1'b0);
      trig = model_ptr;
      for (int k = 0; k < 8; k++) begin
         d = DW'($urandom);
         drive(1'b0, 1'b0, 1'b1, 1'b1, d, AW'(8), c);
         put_sample(d, c);
      end
      exp_c.push_back(c);
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom), AW'(8), c);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      last_trig = trig;
      n_checks++;
      if (trigger_addr !== AW'(trig)) begin
         n_fail++;
         $display("FAIL trig_addr: got %0d want %0d", trigger_addr, trig);
      end
      n_checks++;
      if (got_c.size() != exp_c.size() || (exp_c.size() == 1 && got_c[0] != exp_c[0])) begin
         n_fail++;
         $display("FAIL trig_complete: got %0d pulses first %0d, want %0d pulses at %0d",
                  got_c.size(), got_c.size() > 0 ? got_c[0] : -1, exp_c.size(), exp_c[0]);
      end
      n_checks++;
      if (got_w.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL trig_nwrites: got %0d want %0d", got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
         n_checks++;
         if (got_w[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL trig_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", i, got_w[i].c,
                     got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_wrap;
      int            c;
      int            trig;
      logic [DW-1:0] d;
      go_idle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      for (int j = 0; j < 1030; j++) begin
         if (j == 1023 || j == 1025) begin
            n_checks++;
            if (wrapped !== (model_writes >= DEPTH)) begin
               n_fail++;
               $display("FAIL wrap_flag after %0d writes: got %b want %b", model_writes, wrapped,
                        model_writes >= DEPTH);
            end
         end
         d = DW'($urandom);
         drive(1'b0, 1'b1, 1'b0, 1'b1, d, '0, c);
         put_sample(d, c);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      n_checks++;
      if (wrapped !== (model_writes >= DEPTH)) begin
         n_fail++;
         $display("FAIL wrap_flag after %0d writes: got %b want %b", model_writes, wrapped,
                  model_writes >= DEPTH);
      end
      trig = model_ptr;
      for (int k = 0; k < 2; k++) begin
         d = DW'($urandom);
         drive(1'b0, 1'b0, 1'b1, 1'b1, d, AW'(2), c);
         put_sample(d, c);
      end
      exp_c.push_back(c);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      last_trig = trig;
      n_checks++;
      if (trigger_addr !== AW'(trig)) begin
         n_fail++;
         $display("FAIL wrap_trig_addr: got %0d want %0d", trigger_addr, trig);
      end
      n_checks++;
      if (got_c.size() != exp_c.size() || (exp_c.size() == 1 && got_c[0] != exp_c[0])) begin
         n_fail++;
         $display("FAIL wrap_complete: got %0d pulses first %0d, want %0d pulses at %0d",
                  got_c.size(), got_c.size() > 0 ? got_c[0] : -1, exp_c.size(), exp_c[0]);
      end
      n_checks++;
      if (got_w.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL wrap_nwrites: got %0d want %0d", got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
         n_checks++;
         if (got_w[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL wrap_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", i, got_w[i].c,
                     got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_zero_quota;
      int c;
      int trig;
      go_idle();
      pre_burst(3, 1'b1);
      trig = model_ptr;
      drive(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom), '0, c);
      exp_c.push_back(c);
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom), '0, c);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      last_trig = trig;
      n_checks++;
      if (trigger_addr !== AW'(trig)) begin
         n_fail++;
         $display("FAIL zq_trig_addr: got %0d want %0d", trigger_addr, trig);
      end
      n_checks++;
      if (got_c.size() != exp_c.size() || (exp_c.size() == 1 && got_c[0] != exp_c[0])) begin
         n_fail++;
         $display("FAIL zq_complete: got %0d pulses first %0d, want %0d pulses at %0d",
                  got_c.size(), got_c.size() > 0 ? got_c[0] : -1, exp_c.size(), exp_c[0]);
      end
      n_checks++;
      if (got_w.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL zq_nwrites: got %0d want %0d", got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
         n_checks++;
         if (got_w[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL zq_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", i, got_w[i].c,
                     got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_abort;
      int            c;
      logic [DW-1:0] d;
      go_idle();
      pre_burst(16, 1'b1);
      // Abort with a strobe present: the strobe must be dropped.
      drive(1'b1, 1'b0, 1'b0, 1'b1, DW'($urandom), '0, c);
      model_ptr    = 0;
      model_writes = 0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, c);
      n_checks++;
      if (pageFull !== 1'b1 || wrapped !== 1'b0 || trigger_addr !== AW'(last_trig)) begin
         n_fail++;
         $display("FAIL abort_status: got pf %b wr %b trig %0d, want 1 0 %0d", pageFull, wrapped,
                  trigger_addr, last_trig);
      end
      for (int k = 0; k < 2; k++) begin
         d = DW'($urandom);
         drive(1'b0, 1'b1, 1'b0, 1'b1, d, '0, c);
         put_sample(d, c);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
      n_checks++;
      if (got_c.size() != 0) begin
         n_fail++;
         $display("FAIL abort_complete: got %0d pulses want 0", got_c.size());
      end
      n_checks++;
      if (got_w.size() != exp_w.size()) begin
         n_fail++;
         $display("FAIL abort_nwrites: got %0d want %0d", got_w.size(), exp_w.size());
      end
      foreach (exp_w[i]) if (i < got_w.size()) begin
         n_checks++;
         if (got_w[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL abort_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", i,
                     got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
         end
      end
   endtask

   task automatic test_random;
      int            c;
      int            trig;
      int            quota;
      int            cnt;
      bit            done;
      bit            first;
      logic          v;
      logic [DW-1:0] d;
      logic [AW-1:0] pc;
      for (int it = 0; it < 6; it++) begin
         go_idle();
         pre_burst($urandom_range(0, 40), 1'b1);
         trig  = model_ptr;
         quota = $urandom_range(0, 20);
         cnt   = 0;
         done  = 1'b0;
         first = 1'b1;
         for (int k = 0; k < 400 && !done; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = DW'($urandom);
            // post_count only matters on the first post-trigger cycle.
            pc = first ? AW'(quota) : AW'($urandom);
            drive(1'b0, 1'b0, 1'b1, v, d, pc, c);
            first = 1'b0;
            if (cnt == quota) begin
               done = 1'b1;
               exp_c.push_back(c);
            end else if (v) begin
               put_sample(d, c);
               cnt++;
               if (cnt == quota) begin
                  done = 1'b1;
                  exp_c.push_back(c);
               end
            end
         end
         for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, DW'($urandom), '0, c);
         drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, c);
         last_trig = trig;
         n_checks++;
         if (trigger_addr !== AW'(trig)) begin
            n_fail++;
            $display("FAIL rnd%0d_trig_addr: got %0d want %0d", it, trigger_addr, trig);
         end
         n_checks++;
         if (got_c.size() != exp_c.size() || (exp_c.size() == 1 && got_c[0] != exp_c[0])) begin
            n_fail++;
            $display("FAIL rnd%0d_complete: got %0d pulses first %0d, want %0d pulses at %0d", it,
                     got_c.size(), got_c.size() > 0 ? got_c[0] : -1, exp_c.size(),
                     exp_c.size() > 0 ? exp_c[0] : -1);
         end
         n_checks++;
         if (got_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, got_w.size(), exp_w.size());
         end
         foreach (exp_w[i]) if (i < got_w.size()) begin
            n_checks++;
            if (got_w[i] !== exp_w[i]) begin
               n_fail++;
               $display("FAIL rnd%0d_write[%0d]: got c%0d a%0d d%h want c%0d a%0d d%h", it, i,
                        got_w[i].c, got_w[i].a, got_w[i].d, exp_w[i].c, exp_w[i].a, exp_w[i].d);
            end
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      idle         = 1'b1;
      pre_trigger  = 1'b0;
      post_trigger = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      post_count   = '0;
      test_reset();
      test_pre_fill();
      test_trigger();
      test_wrap();
      test_zero_quota();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
